// File: rtl/mux_3x1_arbiter.sv
// Round-robin arbiter for three requesters with a registered 3:1 mux select.
// Optional forced rotation after MAX_HOLD grant cycles when MUX_ARB_TIMEOUT_EN is defined.
module mux_3x1_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic [1:0] S,
  output logic       busy
);

  localparam int unsigned NREQ = 3;
  localparam int unsigned IDXW = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD out of range 2..255");
  end

  state_t            state, state_n;
  logic [2:0]        grant_n;
  logic [IDXW-1:0]   s_n;
  logic              busy_n;
  logic [IDXW-1:0]   ptr, ptr_n;
  logic [IDXW-1:0]   owner_inc;
  logic [IDXW:0]     pick_idle, pick_next;

  // (p + i) mod 3 for p in 0..2, i in 0..2
  function automatic logic [IDXW-1:0] add3(input logic [IDXW-1:0] p, input logic [IDXW-1:0] i);
    logic [IDXW:0] sum;
    sum = 3'(p) + 3'(i);
    if (sum >= 3'(NREQ)) sum = sum - 3'(NREQ);
    return sum[IDXW-1:0];
  endfunction

  // First set bit of r in round-robin order from p; MSB flags that one was found
  function automatic logic [IDXW:0] rr_pick(input logic [2:0] r, input logic [IDXW-1:0] p);
    logic [IDXW-1:0] idx;
    logic [IDXW:0]   res;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = add3(p, 2'(i));
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign owner_inc = add3(S, 2'd1);
  assign pick_idle = rr_pick(req, ptr);
  assign pick_next = rr_pick(req & ~grant, owner_inc);

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int unsigned CNTW = 8;
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);

  logic [CNTW-1:0] hold_cnt, hold_cnt_n;
  logic            timeout_c;

  assign timeout_c = (hold_cnt == HOLD_LAST) && (|(req & ~grant));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= hold_cnt_n;
  end
`endif

  // Next-state and registered output values
  always_comb begin
    state_n = state;
    grant_n = grant;
    s_n     = S;
    ptr_n   = ptr;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_cnt_n = '0;
`endif
    case (state)
      IDLE: begin
        if (pick_idle[IDXW]) begin
          state_n = OWNED;
          grant_n = 3'b001 << pick_idle[IDXW-1:0];
          s_n     = pick_idle[IDXW-1:0];
        end
      end
      OWNED: begin
        if (!req[S]) begin
          ptr_n = owner_inc;
          if (pick_next[IDXW]) begin
            grant_n = 3'b001 << pick_next[IDXW-1:0];
            s_n     = pick_next[IDXW-1:0];
          end else begin
            state_n = IDLE;
            grant_n = 3'b000;
          end
`ifdef MUX_ARB_TIMEOUT_EN
        end else if (timeout_c) begin
          ptr_n   = owner_inc;
          grant_n = 3'b001 << pick_next[IDXW-1:0];
          s_n     = pick_next[IDXW-1:0];
        end else begin
          hold_cnt_n = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + CNTW'(1);
`endif
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 3'b000;
      end
    endcase
    busy_n = |grant_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= 3'b000;
      S     <= 2'b00;
      busy  <= 1'b0;
      ptr   <= 2'b00;
    end else begin
      state <= state_n;
      grant <= grant_n;
      S     <= s_n;
      busy  <= busy_n;
      ptr   <= ptr_n;
    end
  end

endmodule

// File: tb/tb_mux_3x1_arbiter.sv
// Directed self-checking bench for mux_3x1_arbiter (MAX_HOLD = 4).
`timescale 1ns/1ps
module tb_mux_3x1_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] grant;
  logic [1:0] S;
  logic       busy;

  int checks;
  int errors;

  mux_3x1_arbiter #(.MAX_HOLD(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .grant(grant),
    .S    (S),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] g, input logic [1:0] s, input logic b);
    check({tag, ".grant"}, 8'(grant), 8'(g));
    check({tag, ".S"},     8'(S),     8'(s));
    check({tag, ".busy"},  8'(busy),  8'(b));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 3'b000;
    #1;
    expect_out("reset", 3'b000, 2'b00, 1'b0);
    step();
    expect_out("reset_clk", 3'b000, 2'b00, 1'b0);
    #3 rst_n = 1'b1;

    // all request, each owner drops after its grant
    req = 3'b111;
    step(); expect_out("rr_a", 3'b001, 2'b00, 1'b1);
    req = 3'b110;
    step(); expect_out("rr_b", 3'b010, 2'b01, 1'b1);
    req = 3'b100;
    step(); expect_out("rr_c", 3'b100, 2'b10, 1'b1);
    req = 3'b000;
    step(); expect_out("rr_idle", 3'b000, 2'b10, 1'b0);

    // single B pulse from idle
    req = 3'b010;
    step(); expect_out("pulse_b", 3'b010, 2'b01, 1'b1);
    req = 3'b000;
    step(); expect_out("pulse_rel", 3'b000, 2'b01, 1'b0);
    step(); expect_out("idle_hold", 3'b000, 2'b01, 1'b0);

    // C owner releases with A requesting: wrap-around
    req = 3'b100;
    step(); expect_out("c_own", 3'b100, 2'b10, 1'b1);
    req = 3'b001;
    step(); expect_out("wrap_a", 3'b001, 2'b00, 1'b1);
    req = 3'b000;
    step(); expect_out("wrap_idle", 3'b000, 2'b00, 1'b0);

    // A holds while B requests
    req = 3'b001;
    step(); expect_out("hold_a", 3'b001, 2'b00, 1'b1);
    req = 3'b011;
`ifdef MUX_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step(); check("to_hold", 8'(grant), 8'h01);
    end
    step(); expect_out("to_rotate", 3'b010, 2'b01, 1'b1);
`else
    for (int i = 0; i < 8; i++) begin
      step(); check("nto_hold", 8'(grant), 8'h01);
    end
    req = 3'b010;
    step(); expect_out("nto_rel", 3'b010, 2'b01, 1'b1);
`endif

    // only A requesting: grant persists
    req = 3'b001;
    step(); expect_out("a_alone", 3'b001, 2'b00, 1'b1);
    for (int i = 0; i < 24; i++) begin
      step(); check("a_persist", 8'(grant), 8'h01);
    end
    req = 3'b000;
    step(); expect_out("a_rel", 3'b000, 2'b00, 1'b0);

    // async reset mid-grant
    req = 3'b100;
    step(); expect_out("pre_rst", 3'b100, 2'b10, 1'b1);
    #2 rst_n = 1'b0;
    #1 expect_out("async_rst", 3'b000, 2'b00, 1'b0);
    req = 3'b111;
    step(); expect_out("in_rst", 3'b000, 2'b00, 1'b0);
    #3 rst_n = 1'b1;
    step(); expect_out("post_rst", 3'b001, 2'b00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
